// File: rtl/forward_tracker_pkg.sv
// Shared definitions for the forwarding tracker.
//   FWD_*          : select codes for the decode forwarding mux
//   entry_t        : one tracked pipeline stage (valid, destination, latency)
//   norm_lat       : maps an out-of-range latency (0 or 7) onto 1 (E)
package forward_tracker_pkg;

    localparam int NUM_SRC = 6;

    localparam logic [2:0] FWD_RF = 3'd0;
    localparam logic [2:0] FWD_E  = 3'd1;
    localparam logic [2:0] FWD_M  = 3'd2;
    localparam logic [2:0] FWD_M2 = 3'd3;
    localparam logic [2:0] FWD_M3 = 3'd4;
    localparam logic [2:0] FWD_M4 = 3'd5;
    localparam logic [2:0] FWD_M5 = 3'd6;

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        logic [2:0] lat;
    } entry_t;

    function automatic logic [2:0] norm_lat(input logic [2:0] lat);
        return ((lat == 3'd0) || (lat == 3'd7)) ? 3'd1 : lat;
    endfunction

endpackage

// File: rtl/forward_tracker_select.sv
// Per-source priority match over the tracked stages.
//   entries   : in  stage entries, index 0 = E (youngest) .. DEPTH-1 = M5
//   src       : in  source register being read in decode
//   code      : out forwarding select (stage number of youngest match, 0 = RF)
//   not_ready : out youngest match has not yet produced its result
module forward_select
    import forward_tracker_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  entry_t [DEPTH-1:0] entries,
    input  logic   [5:0]       src,
    output logic   [2:0]       code,
    output logic               not_ready
);

    // Walk oldest to youngest so the youngest match is the one left standing;
    // an older ready copy can never hide a younger pending one.
    always_comb begin
        code      = FWD_RF;
        not_ready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((src != 6'd0) && entries[k].valid && (entries[k].rd == src)) begin
                code      = 3'(k + 1);
                not_ready = (3'(k + 1) < entries[k].lat);
            end
        end
    end

endmodule

// File: rtl/forward_tracker.sv
// Tracks in-flight register writers across stages E..M5 and produces the
// decode forwarding selects plus a RAW-hazard stall.
//   clk, rst                    : clock, asynchronous active-high reset
//   dec_valid/regwrite/rd/lat   : decode instruction and its result latency
//   src0..src5, src_used        : decode source registers and which are consumed
//   flush, freeze               : kill decode instruction / hold every stage
//   forward0..forward5          : forwarding mux selects
//   stall                       : hold fetch/decode and bubble E
module forward_tracker
    import forward_tracker_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic       dec_regwrite,
    input  logic [5:0] dec_rd,
    input  logic [2:0] dec_lat,
    input  logic [5:0] src0,
    input  logic [5:0] src1,
    input  logic [5:0] src2,
    input  logic [5:0] src3,
    input  logic [5:0] src4,
    input  logic [5:0] src5,
    input  logic [5:0] src_used,
    input  logic       flush,
    input  logic       freeze,
    output logic [2:0] forward0,
    output logic [2:0] forward1,
    output logic [2:0] forward2,
    output logic [2:0] forward3,
    output logic [2:0] forward4,
    output logic [2:0] forward5,
    output logic       stall
);

    entry_t [DEPTH-1:0]  entries_q;
    entry_t [DEPTH-1:0]  entries_d;
    entry_t              new_entry;
    logic   [5:0]        src_arr   [NUM_SRC];
    logic   [2:0]        fwd_arr   [NUM_SRC];
    logic   [NUM_SRC-1:0] not_ready;

    assign src_arr[0] = src0;
    assign src_arr[1] = src1;
    assign src_arr[2] = src2;
    assign src_arr[3] = src3;
    assign src_arr[4] = src4;
    assign src_arr[5] = src5;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
        forward_select #(.DEPTH(DEPTH)) u_sel (
            .entries   (entries_q),
            .src       (src_arr[i]),
            .code      (fwd_arr[i]),
            .not_ready (not_ready[i])
        );
    end

    assign forward0 = fwd_arr[0];
    assign forward1 = fwd_arr[1];
    assign forward2 = fwd_arr[2];
    assign forward3 = fwd_arr[3];
    assign forward4 = fwd_arr[4];
    assign forward5 = fwd_arr[5];

    // Unused sources still get a select but cannot raise a hazard.
    assign stall = dec_valid & |(src_used & not_ready);

    always_comb begin
        new_entry.valid = dec_valid & dec_regwrite & ~stall & ~flush & (dec_rd != 6'd0);
        new_entry.rd    = dec_rd;
        new_entry.lat   = norm_lat(dec_lat);

        entries_d = entries_q;
        if (!freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[0] = new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_forward_tracker.sv
module tb_forward_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid, dec_regwrite, flush, freeze;
    logic [5:0] dec_rd;
    logic [2:0] dec_lat;
    logic [5:0] src [6];
    logic [5:0] src_used;
    logic [2:0] fwd [6];
    logic       stall;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: stage k (1=E .. 6=M5) holds the writer accepted k edges ago.
    int m_valid [1:6];
    int m_rd    [1:6];
    int m_lat   [1:6];

    always #5 clk = ~clk;

    forward_tracker dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_regwrite(dec_regwrite),
        .dec_rd(dec_rd), .dec_lat(dec_lat),
        .src0(src[0]), .src1(src[1]), .src2(src[2]),
        .src3(src[3]), .src4(src[4]), .src5(src[5]),
        .src_used(src_used), .flush(flush), .freeze(freeze),
        .forward0(fwd[0]), .forward1(fwd[1]), .forward2(fwd[2]),
        .forward3(fwd[3]), .forward4(fwd[4]), .forward5(fwd[5]),
        .stall(stall)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Youngest stage holding a writer of s, or 0.
    function automatic int m_stage(input int s);
        if (s == 0) return 0;
        for (int k = 1; k <= 6; k++)
            if (m_valid[k] != 0 && m_rd[k] == s) return k;
        return 0;
    endfunction

    function automatic int m_stall();
        int k;
        if (!dec_valid) return 0;
        for (int i = 0; i < 6; i++) begin
            if (src_used[i]) begin
                k = m_stage(int'(src[i]));
                if (k != 0 && k < m_lat[k]) return 1;
            end
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= 6; k++) m_valid[k] <= 0;
        end else if (!freeze) begin
            for (int k = 2; k <= 6; k++) begin
                m_valid[k] <= m_valid[k-1];
                m_rd[k]    <= m_rd[k-1];
                m_lat[k]   <= m_lat[k-1];
            end
            m_valid[1] <= (dec_valid && dec_regwrite && !flush && dec_rd != 0 && m_stall() == 0) ? 1 : 0;
            m_rd[1]    <= int'(dec_rd);
            m_lat[1]   <= (dec_lat == 0 || dec_lat == 7) ? 1 : int'(dec_lat);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++)
            chk($sformatf("model_fwd%0d", i), int'(fwd[i]), m_stage(int'(src[i])));
        chk("model_stall", int'(stall), m_stall());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_regwrite = 0; dec_rd = 0; dec_lat = 3'd1;
        flush = 0; freeze = 0; src_used = 0;
        for (int i = 0; i < 6; i++) src[i] = 0;
    endtask

    task automatic accept(input logic [5:0] rd, input logic [2:0] lat);
        idle();
        dec_valid = 1; dec_regwrite = 1; dec_rd = rd; dec_lat = lat;
    endtask

    task automatic use_src(input int i, input logic [5:0] r);
        idle();
        dec_valid = 1; src[i] = r; src_used[i] = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_fwd0", int'(fwd[0]), 0);
        rst = 0;
        step();

        // ALU result at E, then marching to M5 and out to the register file.
        accept(6'd5, 3'd1);
        step();
        use_src(0, 6'd5);
        #1;
        chk("alu_fwd0_e", int'(fwd[0]), 1);
        chk("alu_stall", int'(stall), 0);
        for (int j = 2; j <= 6; j++) begin
            step();
            chk($sformatf("alu_fwd0_k%0d", j), int'(fwd[0]), j);
        end
        step();
        chk("alu_fwd0_rf", int'(fwd[0]), 0);

        // Load-use: one stall, then forward from M.
        accept(6'd7, 3'd2);
        step();
        use_src(1, 6'd7);
        #1;
        chk("load_stall", int'(stall), 1);
        chk("load_fwd1_e", int'(fwd[1]), 1);
        step();
        chk("load_fwd1_m", int'(fwd[1]), 2);
        chk("load_nostall", int'(stall), 0);

        // FPU lat=5 (M4): pending while in E..M3.
        accept(6'h23, 3'd5);
        step();
        use_src(2, 6'h23);
        for (int j = 1; j <= 4; j++) begin
            #1;
            chk($sformatf("fpu_stall_k%0d", j), int'(stall), 1);
            chk($sformatf("fpu_fwd2_k%0d", j), int'(fwd[2]), j);
            step();
        end
        chk("fpu_fwd2_m4", int'(fwd[2]), 5);
        chk("fpu_nostall", int'(stall), 0);

        // Two writers of x9: younger wins; x0 never forwards.
        accept(6'd9, 3'd1);
        step();
        idle();
        step();
        accept(6'd9, 3'd1);
        step();
        idle();
        dec_valid = 1; dec_regwrite = 1; dec_rd = 6'd0;
        src[3] = 6'd9; src[5] = 6'd0; src_used = 6'b101000;
        #1;
        chk("dup_fwd3", int'(fwd[3]), 1);
        chk("dup_stall", int'(stall), 0);
        chk("x0_fwd5", int'(fwd[5]), 0);
        step();
        chk("x0_fwd5_next", int'(fwd[5]), 0);
        chk("dup_fwd3_next", int'(fwd[3]), 2);

        // Ready older copy must not mask a pending younger one.
        accept(6'd10, 3'd1);
        step();
        idle();
        step();
        accept(6'd10, 3'd3);
        step();
        use_src(0, 6'd10);
        #1;
        chk("mask_fwd0", int'(fwd[0]), 1);
        chk("mask_stall", int'(stall), 1);

        // Flushed writer is never tracked.
        accept(6'd4, 3'd1);
        flush = 1;
        step();
        use_src(4, 6'd4);
        #1;
        chk("flush_fwd4", int'(fwd[4]), 0);

        // Freeze holds a forward from M.
        accept(6'd4, 3'd1);
        step();
        idle();
        step();
        use_src(4, 6'd4);
        freeze = 1;
        #1;
        chk("frz_fwd4_0", int'(fwd[4]), 2);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk($sformatf("frz_fwd4_%0d", j), int'(fwd[4]), 2);
        end
        freeze = 0;
        step();
        chk("frz_release_fwd4", int'(fwd[4]), 3);

        // Latency 0 and 7 behave as 1.
        accept(6'd11, 3'd0);
        step();
        use_src(0, 6'd11);
        #1;
        chk("lat0_stall", int'(stall), 0);
        accept(6'd12, 3'd7);
        step();
        use_src(0, 6'd12);
        #1;
        chk("lat7_stall", int'(stall), 0);
        chk("lat7_fwd0", int'(fwd[0]), 1);

        // Reset while stalled.
        accept(6'd7, 3'd2);
        step();
        use_src(1, 6'd7);
        #1;
        chk("pre_rst_stall", int'(stall), 1);
        rst = 1;
        #1;
        chk("in_rst_stall", int'(stall), 0);
        chk("in_rst_fwd1", int'(fwd[1]), 0);
        step();
        rst = 0;
        #1;
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_fwd1", int'(fwd[1]), 0);
        step();
        chk("post_rst_fwd1_2", int'(fwd[1]), 0);

        // Randomized traffic against the reference.
        repeat (3000) begin
            dec_valid    = ($urandom_range(0, 9) != 0);
            dec_regwrite = ($urandom_range(0, 3) != 0);
            dec_rd       = 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
            dec_lat      = 3'($urandom_range(0, 7));
            for (int i = 0; i < 6; i++)
                src[i] = 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
            src_used = 6'($urandom_range(0, 63));
            flush    = ($urandom_range(0, 9) == 0);
            freeze   = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
